// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Op encoding, FSM states and the signed-magnitude helper.
package mdu_pkg;

    localparam logic [2:0] MDU_MULW   = 3'd0;
    localparam logic [2:0] MDU_MULHW  = 3'd1;
    localparam logic [2:0] MDU_MULHWU = 3'd2;
    localparam logic [2:0] MDU_DIV    = 3'd3;
    localparam logic [2:0] MDU_DIVU   = 3'd4;
    localparam logic [2:0] MDU_MOD    = 3'd5;
    localparam logic [2:0] MDU_MODU   = 3'd6;

    localparam int MDU_MAXW = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } mdu_state_e;

    // Low bits of a negation depend only on low bits, so callers may
    // zero-extend into this width and truncate the answer back.
    function automatic logic [MDU_MAXW-1:0] mdu_mag(
        input logic [MDU_MAXW-1:0] v,
        input logic                neg
    );
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in a dividend bit,
// subtract the divisor if it fits and emit the quotient bit.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic             bit_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    logic [WIDTH+1:0] sh;
    logic [WIDTH+1:0] diff;

    assign sh    = {rem_i, bit_i};
    assign diff  = sh - {2'b00, div_i};
    assign q_o   = ~diff[WIDTH+1];
    assign rem_o = q_o ? diff[WIDTH:0] : sh[WIDTH:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for the EX stage.
// Shift-add multiplier and restoring divider, one op in flight.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int MUL_N = WIDTH / MUL_BITS;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int W2    = 2 * WIDTH;

    mdu_state_e       state_q;
    logic [2:0]       op_q;
    logic             div_q, s1_q, s2_q, dz_q;
    logic             in_ready_q, out_valid_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] src1_q, mr_q, dv_q, result_q;
    logic [W2-1:0]    mc_q, acc_q;
    logic [WIDTH:0]   rem_q;

    logic             is_div, is_sgn, n1, n2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [W2-1:0]    pp_d, prod_d;
    logic [WIDTH:0]   rem_d;
    logic             qbit_d;
    logic [WIDTH-1:0] quo_d, rmd_d, res_d;

    always_comb begin
        is_div = op inside {MDU_DIV, MDU_DIVU, MDU_MOD, MDU_MODU};
        is_sgn = op inside {MDU_MULHW, MDU_DIV, MDU_MOD};
        n1     = is_sgn & src1[WIDTH-1];
        n2     = is_sgn & src2[WIDTH-1];
        mag1   = WIDTH'(mdu_mag(MDU_MAXW'(src1), n1));
        mag2   = WIDTH'(mdu_mag(MDU_MAXW'(src2), n2));
    end

    assign pp_d = mc_q * W2'(mr_q[MUL_BITS-1:0]);

    div_iter_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i (rem_q),
        .div_i (dv_q),
        .bit_i (mr_q[WIDTH-1]),
        .rem_o (rem_d),
        .q_o   (qbit_d)
    );

    // Sign fixup runs in its own cycle, after the last iteration.
    always_comb begin
        prod_d = (s1_q ^ s2_q) ? -acc_q : acc_q;
        quo_d  = (s1_q ^ s2_q) ? -mr_q : mr_q;
        rmd_d  = s1_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        res_d  = prod_d[WIDTH-1:0];
        case (op_q)
            MDU_MULHW, MDU_MULHWU: res_d = prod_d[W2-1:WIDTH];
            MDU_DIV, MDU_DIVU:     res_d = dz_q ? '1 : quo_d;
            MDU_MOD, MDU_MODU:     res_d = dz_q ? src1_q : rmd_d;
            default:               ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            op_q        <= MDU_MULW;
            div_q       <= 1'b0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            src1_q      <= '0;
            mr_q        <= '0;
            dv_q        <= '0;
            result_q    <= '0;
            mc_q        <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q       <= op;
                        div_q      <= is_div;
                        s1_q       <= n1;
                        s2_q       <= n2;
                        dz_q       <= (src2 == '0);
                        src1_q     <= src1;
                        mc_q       <= W2'(mag1);
                        mr_q       <= is_div ? mag1 : mag2;
                        dv_q       <= mag2;
                        acc_q      <= '0;
                        rem_q      <= '0;
                        cnt_q      <= is_div ? CW'(WIDTH) : CW'(MUL_N);
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                        if (div_q) begin
                            rem_q <= rem_d;
                            mr_q  <= {mr_q[WIDTH-2:0], qbit_d};
                        end else begin
                            acc_q <= acc_q + pp_d;
                            mc_q  <= mc_q << MUL_BITS;
                            mr_q  <= mr_q >> MUL_BITS;
                        end
                    end else begin
                        result_q    <= res_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
